// File: rtl/spi_slave_regs.sv
// spi_slave_regs - SPI mode 0 responder with a byte-wide register bank.
//
// Frames are two bytes: {rw, addr[6:0]} followed by data (MOSI on writes,
// MISO on reads). Register 0 holds a read-only ID value; addresses at or
// above NUM_REGS are unmapped (writes ignored, reads return 0x00).
// All pin inputs are asynchronous and are oversampled in the clk domain.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   cs_n       SPI chip select, active low (async)
//   sck        SPI clock, idle low (async)
//   mosi       master-out data (async)
//   miso       slave-out data
//   miso_oe    MISO drive enable while a frame is selected
//   regs_flat  register contents, reg i at [8i+7:8i]
//   wr_stb     one-cycle pulse on a register update
//   wr_addr    address of the last write
//   wr_data    data of the last write
//   rd_stb     one-cycle pulse when read data is latched
//   frame_done one-cycle pulse at the end of a 16-bit frame
//   frame_err  one-cycle pulse at the end of a malformed frame
module spi_slave_regs #(
   parameter int         NUM_REGS = 16,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs_n,
   input  logic                  sck,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   output logic [NUM_REGS*8-1:0] regs_flat,
   output logic                  wr_stb,
   output logic [6:0]            wr_addr,
   output logic [7:0]            wr_data,
   output logic                  rd_stb,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

   localparam logic [2:0] WAIT_CS = 3'd0;
   localparam logic [2:0] IDLE    = 3'd1;
   localparam logic [2:0] ADDR    = 3'd2;
   localparam logic [2:0] DATA    = 3'd3;
   localparam logic [2:0] OVER    = 3'd4;

   // Synchronizers are deliberately not reset: they must keep tracking the
   // pins during reset so WAIT_CS sees the true cs_n level on release.
   logic [2:0] cs_sync_reg;
   logic [2:0] sck_sync_reg;
   logic [1:0] mosi_sync_reg;

   always_ff @(posedge clk) begin
      cs_sync_reg   <= {cs_sync_reg[1:0], cs_n};
      sck_sync_reg  <= {sck_sync_reg[1:0], sck};
      mosi_sync_reg <= {mosi_sync_reg[0], mosi};
   end

   logic cs_level, cs_rise, cs_fall, sck_rise, sck_fall, mosi_bit;
   assign cs_level = cs_sync_reg[1];
   assign cs_rise  =  cs_sync_reg[1] & ~cs_sync_reg[2];
   assign cs_fall  = ~cs_sync_reg[1] &  cs_sync_reg[2];
   assign sck_rise =  sck_sync_reg[1] & ~sck_sync_reg[2];
   assign sck_fall = ~sck_sync_reg[1] &  sck_sync_reg[2];
   assign mosi_bit = mosi_sync_reg[1];

   logic [2:0] state_reg;
   logic [4:0] cnt_reg;
   logic [6:0] shift_reg;
   logic [7:0] rd_shift_reg;
   logic       rw_reg;
   logic [6:0] addr_reg;
   logic [7:0] regs_reg [NUM_REGS];

   // Byte completed by the current sck rise (7 held bits plus the new one).
   logic [7:0] byte_in;
   logic       addr_in_mapped;
   logic       addr_mapped;
   logic [7:0] rd_value;

   assign byte_in        = {shift_reg, mosi_bit};
   assign addr_in_mapped = {1'b0, byte_in[6:0]} < NUM_REGS_W;
   assign addr_mapped    = {1'b0, addr_reg} < NUM_REGS_W;

   always_comb begin
      rd_value = 8'h00;
      if (addr_in_mapped)
         rd_value = regs_reg[byte_in[AW-1:0]];
   end

   assign miso_oe = ((state_reg == ADDR) || (state_reg == DATA) ||
                     (state_reg == OVER)) && !cs_level;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= WAIT_CS;
         cnt_reg      <= 5'd0;
         shift_reg    <= 7'd0;
         rd_shift_reg <= 8'd0;
         rw_reg       <= 1'b0;
         addr_reg     <= 7'd0;
         miso         <= 1'b0;
         wr_stb       <= 1'b0;
         rd_stb       <= 1'b0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
         wr_addr      <= 7'd0;
         wr_data      <= 8'd0;
         for (int i = 0; i < NUM_REGS; i++)
            regs_reg[i] <= (i == 0) ? ID_VALUE : 8'h00;
      end else begin
         wr_stb     <= 1'b0;
         rd_stb     <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (miso_oe_state(state_reg) && cs_rise) begin
            // cs_n rise closes the frame and masks any same-cycle sck edge.
            state_reg <= IDLE;
            miso      <= 1'b0;
            if (cnt_reg == 5'd16)
               frame_done <= 1'b1;
            else if (cnt_reg != 5'd0)
               frame_err <= 1'b1;
         end else begin
            case (state_reg)
               WAIT_CS: begin
                  miso <= 1'b0;
                  if (cs_level)
                     state_reg <= IDLE;
               end
               IDLE: begin
                  miso      <= 1'b0;
                  cnt_reg   <= 5'd0;
                  shift_reg <= 7'd0;
                  if (cs_fall)
                     state_reg <= ADDR;
               end
               ADDR: begin
                  miso <= 1'b0;
                  if (sck_rise) begin
                     shift_reg <= byte_in[6:0];
                     cnt_reg   <= cnt_reg + 5'd1;
                     if (cnt_reg == 5'd7) begin
                        rw_reg    <= byte_in[7];
                        addr_reg  <= byte_in[6:0];
                        state_reg <= DATA;
                        if (byte_in[7]) begin
                           rd_shift_reg <= rd_value;
                           rd_stb       <= 1'b1;
                        end
                     end
                  end
               end
               DATA: begin
                  if (sck_fall && rw_reg) begin
                     miso         <= rd_shift_reg[7];
                     rd_shift_reg <= {rd_shift_reg[6:0], 1'b0};
                  end
                  if (sck_rise) begin
                     shift_reg <= byte_in[6:0];
                     cnt_reg   <= cnt_reg + 5'd1;
                     if (cnt_reg == 5'd15) begin
                        state_reg <= OVER;
                        if (!rw_reg && addr_mapped && (addr_reg != 7'd0)) begin
                           regs_reg[addr_reg[AW-1:0]] <= byte_in;
                           wr_addr <= addr_reg;
                           wr_data <= byte_in;
                           wr_stb  <= 1'b1;
                        end
                     end
                  end
               end
               OVER: begin
                  miso <= 1'b0;
                  if (sck_rise && (cnt_reg != 5'd31))
                     cnt_reg <= cnt_reg + 5'd1;
               end
               default: state_reg <= WAIT_CS;
            endcase
         end
      end
   end

   function automatic logic miso_oe_state(input logic [2:0] s);
      return (s == ADDR) || (s == DATA) || (s == OVER);
   endfunction

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
         assign regs_flat[8*gi +: 8] = regs_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs - directed bench for spi_slave_regs. A task plays the
// SPI mode 0 master; a negedge monitor counts strobes; all comparisons use
// the check task against hand-computed values.
module tb_spi_slave_regs;

   localparam int NUM_REGS = 16;
   localparam int HALF     = 5;   // sck half-period in clk cycles

   logic                  clk = 1'b0;
   logic                  rst_n, cs_n, sck, mosi;
   logic                  miso, miso_oe;
   logic [NUM_REGS*8-1:0] regs_flat;
   logic                  wr_stb, rd_stb, frame_done, frame_err;
   logic [6:0]            wr_addr;
   logic [7:0]            wr_data;

   spi_slave_regs #(.NUM_REGS(NUM_REGS), .ID_VALUE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .regs_flat(regs_flat),
      .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_stb(rd_stb), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0;
   int w0, r0, d0, e0;

   always @(negedge clk) begin
      if (wr_stb)     wr_cnt++;
      if (rd_stb)     rd_cnt++;
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   function automatic logic [31:0] get_reg(input int i);
      return 32'(regs_flat[8*i +: 8]);
   endfunction

   task automatic snap();
      w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt;
   endtask

   // Mode 0 master: mosi set while sck low, miso sampled at each rise.
   // rst_at >= 0 pulses rst_n just before that bit is driven.
   task automatic spi_frame(input logic [31:0] tx, input int nbits, input int rst_at,
                            output logic [31:0] rx, output logic oe_mid);
      rx = 32'd0;
      oe_mid = 1'b0;
      @(negedge clk);
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
         mosi = tx[nbits-1-i];
         repeat (HALF) @(negedge clk);
         if (i == nbits / 2) oe_mid = miso_oe;
         rx  = {rx[30:0], miso};
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] rx;
      logic        oe;
      logic [7:0]  acc;
      rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Reset state
      check("rst miso",    32'(miso), 32'd0);
      check("rst miso_oe", 32'(miso_oe), 32'd0);
      check("rst wr_addr", 32'(wr_addr), 32'd0);
      check("rst wr_data", 32'(wr_data), 32'd0);
      check("rst reg0",    get_reg(0), 32'hA5);
      check("rst reg5",    get_reg(5), 32'd0);
      check("rst strobes", 32'(wr_cnt + rd_cnt + done_cnt + err_cnt), 32'd0);

      // Write 0x05 <- 0x3C
      snap();
      spi_frame(32'h053C, 16, -1, rx, oe);
      check("wr05 wr_stb",  32'(wr_cnt - w0), 32'd1);
      check("wr05 wr_addr", 32'(wr_addr), 32'h05);
      check("wr05 wr_data", 32'(wr_data), 32'h3C);
      check("wr05 reg5",    get_reg(5), 32'h3C);
      check("wr05 done",    32'(done_cnt - d0), 32'd1);
      check("wr05 err",     32'(err_cnt - e0), 32'd0);

      // Read 0x05
      snap();
      spi_frame(32'h8500, 16, -1, rx, oe);
      check("rd05 rd_stb",  32'(rd_cnt - r0), 32'd1);
      check("rd05 data",    32'(rx[7:0]), 32'h3C);
      check("rd05 done",    32'(done_cnt - d0), 32'd1);
      check("rd05 oe mid",  32'(oe), 32'd1);
      check("rd05 oe idle", 32'(miso_oe), 32'd0);
      check("rd05 wr_stb",  32'(wr_cnt - w0), 32'd0);

      // ID register read and ignored write to 0x00
      spi_frame(32'h8000, 16, -1, rx, oe);
      check("rd00 data", 32'(rx[7:0]), 32'hA5);
      snap();
      spi_frame(32'h0012, 16, -1, rx, oe);
      check("wr00 wr_stb",  32'(wr_cnt - w0), 32'd0);
      check("wr00 reg0",    get_reg(0), 32'hA5);
      check("wr00 done",    32'(done_cnt - d0), 32'd1);
      check("wr00 wr_addr", 32'(wr_addr), 32'h05);

      // Unmapped address 0x20
      snap();
      spi_frame(32'h2077, 16, -1, rx, oe);
      spi_frame(32'hA000, 16, -1, rx, oe);
      check("unmap wr_stb", 32'(wr_cnt - w0), 32'd0);
      check("unmap rdata",  32'(rx[7:0]), 32'h00);
      check("unmap done",   32'(done_cnt - d0), 32'd2);

      // Empty selection: no pulses
      snap();
      spi_frame(32'h0, 0, -1, rx, oe);
      check("empty pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);

      // 12-bit aborted write to 0x04
      snap();
      spi_frame(32'h045, 12, -1, rx, oe);
      check("abort wr_stb", 32'(wr_cnt - w0), 32'd0);
      check("abort err",    32'(err_cnt - e0), 32'd1);
      check("abort done",   32'(done_cnt - d0), 32'd0);
      check("abort reg4",   get_reg(4), 32'd0);

      // 18-bit write to 0x03 <- 0x5A: write kept, frame flagged
      snap();
      spi_frame(32'h0D6B, 18, -1, rx, oe);
      check("long wr_stb", 32'(wr_cnt - w0), 32'd1);
      check("long reg3",   get_reg(3), 32'h5A);
      check("long err",    32'(err_cnt - e0), 32'd1);
      check("long done",   32'(done_cnt - d0), 32'd0);

      // Reset at bit 5 of a write to 0x07, sck keeps running with cs_n low
      snap();
      spi_frame(32'h0744, 16, 5, rx, oe);
      acc = 8'h00;
      for (int i = 1; i < NUM_REGS; i++) acc = acc | regs_flat[8*i +: 8];
      check("mrst strobes", 32'(wr_cnt - w0 + rd_cnt - r0 + done_cnt - d0 + err_cnt - e0), 32'd0);
      check("mrst regs",    32'(acc), 32'd0);
      check("mrst reg0",    get_reg(0), 32'hA5);

      // Recovery write 0x02 <- 0x99
      snap();
      spi_frame(32'h0299, 16, -1, rx, oe);
      check("rec wr_stb",  32'(wr_cnt - w0), 32'd1);
      check("rec reg2",    get_reg(2), 32'h99);
      check("rec wr_addr", 32'(wr_addr), 32'h02);
      check("rec done",    32'(done_cnt - d0), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- Synthesizable SPI Mode 0 responder (slave) with a small byte-wide register bank.
- Answers the two-byte frames produced by the SoC SPI master. Byte 0 is {R/W, addr[6:0]}, with R/W=1 meaning read. Byte 1 is data, on MOSI for writes and on MISO for reads.
- Used as the device model on the unit bench and as a reusable on-chip peripheral.
- Pin inputs are asynchronous to clk; they are oversampled and edge-detected in the clk domain.

Parameters:
- NUM_REGS, 16, number of implemented registers (2..128); addresses >= NUM_REGS are unmapped.
- ID_VALUE, 8'hA5, read-only contents of register 0x00.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- cs_n  input  1  SPI chip select, active low, asynchronous
- sck  input  1  SPI clock, idle low, asynchronous
- mosi  input  1  master-out data, asynchronous
- miso  output  1  slave-out data
- miso_oe  output  1  MISO drive enable, high while a frame is selected
- regs_flat  output  NUM_REGS*8  register contents; reg i occupies bits [8i+7:8i]
- wr_stb  output  1  one-cycle pulse when a mapped, writable register is updated
- wr_addr  output  7  address of the current or last write
- wr_data  output  8  data of the current or last write
- rd_stb  output  1  one-cycle pulse when read data is latched
- frame_done  output  1  one-cycle pulse at the end of a well-formed 16-bit frame
- frame_err  output  1  one-cycle pulse at the end of a malformed frame

Behaviour:
- Reset (rst_n low at posedge clk):
  - miso, miso_oe, wr_stb, rd_stb, frame_done and frame_err = 0; wr_addr = 0; wr_data = 0.
  - All registers = 0, except reg 0 = ID_VALUE. Bit counter = 0.
  - State = WAIT_CS.
- Synchronizers: cs_n, sck and mosi each pass through 2 flops, plus a third flop for edge detect.
  - A pin edge is acted on 3 clk cycles after it occurs.
  - Requirement on the master: sck half-period >= 4 clk.
- States:
  - WAIT_CS: no activity. Moves to IDLE when synced cs_n = 1.
  - IDLE: moves to ADDR when synced cs_n falls. Clears the bit counter and shift register.
  - ADDR: on each sck rise, shift mosi in MSB-first and increment the counter.
    - On the 8th rise, latch rw and addr, then go to DATA.
    - On a read, also load the read shift register with reg[addr] (0x00 if unmapped) and pulse rd_stb for 1 cycle.
  - DATA:
    - Read: on each sck fall, miso = next shift-register bit, MSB-first. bit7 appears on the 8th fall, i.e. before the 9th rise.
    - Write: shift mosi on each rise.
    - On the 16th rise with a write to a mapped, nonzero address: update the register, set wr_addr/wr_data, and pulse wr_stb in the next cycle. Then go to OVER.
  - OVER: further sck rises saturate the counter (5 bits, max 31). miso = 0.
- Frame end: synced cs_n rising edge in any active state returns to IDLE.
  - Pulse frame_done if the count is exactly 16.
  - Pulse frame_err if the count is 1..15 or >16.
  - No pulse if the count is 0.
  - A partial frame never writes. A frame longer than 16 bits keeps the write made at bit 16 and pulses frame_err.
- Registers:
  - Writes to addr 0x00 or unmapped addresses are ignored: no wr_stb, frame_done still pulses.
  - Unmapped reads return 0x00.
- MISO:
  - miso = 0 during ADDR, IDLE and WAIT_CS.
  - miso_oe = synced !cs_n while the state is ADDR, DATA or OVER; 0 otherwise.
- Edge priorities within one clk cycle:
  - A cs_n rise overrides a same-cycle sck edge; the frame is closed and the edge ignored.
  - rst_n overrides everything.
- Reset while cs_n is low: stay in WAIT_CS and ignore all sck activity until cs_n is seen high. No strobes are emitted for the aborted frame.
- sck edges while cs_n is high are ignored.

Test Plan:
- Write frame 0x05, 0x3C → wr_stb pulses once with wr_addr=0x05 and wr_data=0x3C; regs_flat[47:40]=0x3C; frame_done pulses; frame_err stays 0.
- After the previous write, read frame 0x85 → rd_stb pulses; miso carries 0,0,1,1,1,1,0,0 sampled on rises 9..16; frame_done pulses.
- Read frame 0x80 → returns 0xA5. Write frame 0x00, 0x12 → no wr_stb; reg 0 still 0xA5; frame_done pulses.
- With NUM_REGS=16, write 0x20, 0x77 then read 0xA0 → no wr_stb; read returns 0x00; two frame_done pulses.
- Write frame aborted after 12 bits (cs_n raised) → no wr_stb; frame_err pulses; an 18-bit write frame to 0x03 updates reg 3 and pulses frame_err.
- Assert rst_n low at bit 5 of a write, release it, and keep clocking sck with cs_n low → no strobes and no register change. After cs_n goes high, a new write 0x02, 0x99 succeeds.
